// File: rtl/matmul2x2_seq_pkg.sv
// Shared types and constants for the 2x2 matrix-multiply sequencer.
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_MUL  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  localparam int unsigned N_ELEM = 8;
  localparam int unsigned N_STEP = 8;
  localparam int unsigned N_RES  = 4;

  localparam int unsigned EC_W = $clog2(N_ELEM);
  localparam int unsigned SC_W = $clog2(N_STEP);
  localparam int unsigned RI_W = $clog2(N_RES);

  // Operand slot order matches the nibble-serial arrival order.
  localparam int unsigned SLOT_A00 = 0;
  localparam int unsigned SLOT_A01 = 1;
  localparam int unsigned SLOT_A10 = 2;
  localparam int unsigned SLOT_A11 = 3;
  localparam int unsigned SLOT_B00 = 4;
  localparam int unsigned SLOT_B01 = 5;
  localparam int unsigned SLOT_B10 = 6;
  localparam int unsigned SLOT_B11 = 7;

endpackage

// File: rtl/matmul2x2_seq_if.sv
// Operand-in / result-out valid/ready bundle of the sequencer.
interface matmul2x2_seq_if #(
  parameter int unsigned W = 4
) ();
  localparam int unsigned RW = 2 * W + 1;

  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [RW-1:0] out_data;
  logic          out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/matmul2x2_seq_mul.sv
// Combinational unsigned WxW ripple array multiplier built from full-adder cells.
module mul4x4_array #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  function automatic logic [1:0] fa_cell(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  logic [2*W-1:0] acc;
  logic           cy;
  logic [1:0]     fs;

  // Row i adds partial product a*b[i] into bits i..i+W of the running sum.
  always_comb begin
    acc          = '0;
    cy           = 1'b0;
    fs           = 2'b00;
    acc[W-1:0]   = a_i & {W{b_i[0]}};
    for (int i = 1; i < int'(W); i++) begin
      cy = 1'b0;
      for (int k = 0; k < int'(W); k++) begin
        fs         = fa_cell(acc[i+k], a_i[k] & b_i[i], cy);
        acc[i+k]   = fs[0];
        cy         = fs[1];
      end
      acc[i+int'(W)] = cy;
    end
    p_o = acc;
  end

endmodule

// File: rtl/matmul2x2_seq.sv
// 2x2 matrix product sequencer sharing one array multiplier across 8 partial products.
module matmul2x2_seq
  import matmul_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  matmul2x2_seq_if.slave  bus,
  output logic            busy
);

  localparam int unsigned RW = 2 * W + 1;
  localparam int unsigned PW = 2 * W;

  state_e          state_q, state_d;
  logic [EC_W-1:0] ec_q, ec_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [RI_W-1:0] ri_q, ri_d;
  logic [W-1:0]    opnd_q [N_ELEM];
  logic [W-1:0]    opnd_d [N_ELEM];
  logic [RW-1:0]   c_q    [N_RES];
  logic [RW-1:0]   c_d    [N_RES];

  logic [W-1:0]    mul_a, mul_b;
  logic [PW-1:0]   prod;
  logic            in_fire, out_fire;

  // Step sc = {i, j, t}: A[i][t] sits at slot {0,i,t}, B[t][j] at slot {1,t,j}.
  assign mul_a = opnd_q[{1'b0, sc_q[2], sc_q[0]}];
  assign mul_b = opnd_q[{1'b1, sc_q[0], sc_q[1]}];

  mul4x4_array #(.W(W)) u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (prod)
  );

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_data  = (state_q == ST_OUT) ? c_q[ri_q] : '0;
  assign busy          = (state_q == ST_MUL) || (state_q == ST_OUT);

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  // Next-state and datapath update; clear wins over any handshake.
  always_comb begin
    state_d = state_q;
    ec_d    = ec_q;
    sc_d    = sc_q;
    ri_d    = ri_q;
    opnd_d  = opnd_q;
    c_d     = c_q;

    if (clear) begin
      state_d = ST_LOAD;
      ec_d    = '0;
      sc_d    = '0;
      ri_d    = '0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (in_fire) begin
            opnd_d[ec_q] = bus.in_data;
            if (ec_q == EC_W'(N_ELEM - 1)) begin
              ec_d    = '0;
              sc_d    = '0;
              state_d = ST_MUL;
            end else begin
              ec_d = ec_q + EC_W'(1);
            end
          end
        end
        ST_MUL: begin
          if (!sc_q[0]) c_d[sc_q[2:1]] = RW'(prod);
          else          c_d[sc_q[2:1]] = c_q[sc_q[2:1]] + RW'(prod);
          if (sc_q == SC_W'(N_STEP - 1)) begin
            sc_d    = '0;
            ri_d    = '0;
            state_d = ST_OUT;
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
        ST_OUT: begin
          if (out_fire) begin
            if (ri_q == RI_W'(N_RES - 1)) begin
              ri_d    = '0;
              state_d = ST_LOAD;
            end else begin
              ri_d = ri_q + RI_W'(1);
            end
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      ec_q    <= '0;
      sc_q    <= '0;
      ri_q    <= '0;
      for (int e = 0; e < int'(N_ELEM); e++) opnd_q[e] <= '0;
      for (int r = 0; r < int'(N_RES); r++)  c_q[r]    <= '0;
    end else begin
      state_q <= state_d;
      ec_q    <= ec_d;
      sc_q    <= sc_d;
      ri_q    <= ri_d;
      opnd_q  <= opnd_d;
      c_q     <= c_d;
    end
  end

endmodule

// File: tb/tb_matmul2x2_seq.sv
// Directed scoreboard bench for matmul2x2_seq.
module tb_matmul2x2_seq;

  localparam int unsigned W  = 4;
  localparam int unsigned RW = 2 * W + 1;

  logic clk;
  logic rst_n;
  logic clear;
  logic busy;

  matmul2x2_seq_if #(.W(W)) bus ();

  matmul2x2_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus.slave),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q [$];
  int ma [4];
  int mb [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"},  32'(bus.out_data),  32'd0);
    check({tag, "_busy"},      32'(busy),          32'd0);
  endtask

  task automatic send_elem(input int v, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'(v);
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    check("no_out_during_load", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Reference model: C[i][j] = A[i][0]*B[0][j] + A[i][1]*B[1][j].
  task automatic send_mat(input bit gaps, input bit push);
    if (push) begin
      for (int r = 0; r < 4; r++) begin
        int i = r / 2;
        int j = r % 2;
        exp_q.push_back(RW'(ma[2*i] * mb[j] + ma[2*i+1] * mb[2+j]));
      end
    end
    for (int e = 0; e < 4; e++) send_elem(ma[e], gaps);
    for (int e = 0; e < 4; e++) send_elem(mb[e], gaps);
  endtask

  task automatic receive(input int n, input int hold_k, input int hold_n, input int exp_lat);
    int cnt;
    logic [RW-1:0] e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cnt = 0;
      if (k == 0 && exp_lat >= 0) begin
        check("mul_busy", 32'(busy), 32'd1);
        check("mul_in_ready", 32'(bus.in_ready), 32'd0);
      end
      while (!bus.out_valid && cnt < 40) begin
        check("out_data_zero_when_invalid", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        cnt++;
      end
      check("out_valid_wait", 32'(bus.out_valid), 32'd1);
      if (k == 0 && exp_lat >= 0) check("first_valid_latency", 32'(cnt), 32'(exp_lat));
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        e = '0;
      end else begin
        e = exp_q.pop_front();
      end
      if (k == hold_k) begin
        bus.out_ready = 1'b0;
        for (int h = 0; h < hold_n; h++) begin
          check("hold_valid", 32'(bus.out_valid), 32'd1);
          check("hold_data", 32'(bus.out_data), 32'(e));
          @(negedge clk);
        end
        bus.out_ready = 1'b1;
      end
      check("out_data", 32'(bus.out_data), 32'(e));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    idle_check("reset");
    rst_n = 1'b1;
    @(negedge clk);
    idle_check("post_reset");

    // Basic product, back-to-back elements; first valid follows edge T+8.
    ma = '{1, 2, 3, 4};
    mb = '{5, 6, 7, 8};
    send_mat(1'b0, 1'b1);
    receive(4, -1, 0, 8);
    @(negedge clk);
    idle_check("after_out");

    ma = '{15, 15, 15, 15};
    mb = '{15, 15, 15, 15};
    send_mat(1'b0, 1'b1);
    receive(4, -1, 0, 8);

    ma = '{0, 0, 0, 0};
    mb = '{0, 0, 0, 0};
    send_mat(1'b0, 1'b1);
    receive(4, -1, 0, 8);

    // Input gaps and a 5-cycle stall on the second result (22).
    ma = '{1, 2, 3, 4};
    mb = '{5, 6, 7, 8};
    send_mat(1'b1, 1'b1);
    receive(4, 1, 5, 8);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Clear during MUL at sc=3, then identity times [[9,8],[7,6]].
    ma = '{3, 5, 7, 11};
    mb = '{2, 4, 6, 8};
    send_mat(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("clear_pre_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_in_ready", 32'(bus.in_ready), 32'd1);
    check("clear_out_valid", 32'(bus.out_valid), 32'd0);
    check("clear_busy", 32'(busy), 32'd0);
    ma = '{1, 0, 0, 1};
    mb = '{9, 8, 7, 6};
    send_mat(1'b0, 1'b1);
    receive(4, -1, 0, 8);

    // Asynchronous reset while presenting result index 2.
    ma = '{2, 3, 4, 5};
    mb = '{6, 7, 8, 9};
    send_mat(1'b0, 1'b1);
    receive(2, -1, 0, 8);
    @(negedge clk);
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_check("rst_release");
    ma = '{7, 1, 2, 9};
    mb = '{3, 14, 5, 6};
    send_mat(1'b1, 1'b1);
    receive(4, -1, 0, 8);

    // Clear coincident with the final accept: no MUL, counter back to 0.
    ma = '{4, 4, 4, 4};
    mb = '{4, 4, 4, 4};
    for (int e = 0; e < 7; e++) send_elem(e < 4 ? ma[e] : mb[e-4], 1'b0);
    @(negedge clk);
    check("ec7_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd4;
    clear        = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    clear        = 1'b0;
    repeat (3) begin
      @(negedge clk);
      idle_check("ec7_clear");
    end
    ma = '{1, 2, 3, 4};
    mb = '{5, 6, 7, 8};
    send_mat(1'b0, 1'b1);
    receive(4, -1, 0, 8);
    check("final_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL global_timeout: observed running expected finished");
  end

endmodule
